inst_queue: RTL and testbench

Decoupling instruction queue between the fetch-output register stage and the decoder. It accepts one fetch bundle per cycle (up to two instructions, with PC, prediction and exception sideband) and splits it into per-instruction entries. It presents the two oldest entries to decode, which pops 0, 1 or 2 entries per cycle. The block also generates the back-pressure signals (`fifo_allowin`, `space_ok`, `nearly_full`) the fetch stage uses to throttle I-cache requests.

---
 rtl/inst_queue_pkg.sv | 26 ++
 rtl/inst_queue_ram.sv | 32 +++
 rtl/inst_queue.sv | 155 +++++++++++++++
 tb/tb_inst_queue.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants and the queue entry layout for the fetch-to-decode instruction queue.
package inst_queue_pkg;

    localparam logic [31:0] INST_NOP = 32'h0340_0000;
    localparam logic [31:0] PC_RESET = 32'h1C00_0000;
    localparam int unsigned ENTRY_W  = 32 * 4 + 1 + 7 + 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc_next;
        logic        taken;
        logic [31:0] badv;
        logic [6:0]  exception;
        logic [1:0]  excp_flag;
    } iq_entry_t;

    // Value presented on an output slot that holds no entry.
    function automatic iq_entry_t idle_entry();
        iq_entry_t e;
        e      = '0;
        e.inst = INST_NOP;
        return e;
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage: two write ports (tail, tail+1) and two combinational read ports (head, head+1).
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we0_i,
    input  logic [PW-1:0]   wa0_i,
    input  iq_entry_t       wd0_i,
    input  logic            we1_i,
    input  logic [PW-1:0]   wa1_i,
    input  iq_entry_t       wd1_i,
    input  logic [PW-1:0]   ra0_i,
    input  logic [PW-1:0]   ra1_i,
    output iq_entry_t       rd0_o,
    output iq_entry_t       rd1_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (we0_i) mem_q[wa0_i] <= wd0_i;
        if (we1_i) mem_q[wa1_i] <= wd1_i;
    end

    assign rd0_o = iq_entry_t'(mem_q[ra0_i]);
    assign rd1_o = iq_entry_t'(mem_q[ra1_i]);

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: splits fetch bundles into entries,
// presents the two oldest to decode and generates fetch back-pressure.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        fifo_allowin,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_pc_next,
    input  logic [31:0] in_badv,
    input  logic        in_pc_taken,
    input  logic [31:0] in_inst0,
    input  logic [31:0] in_inst1,
    input  logic [6:0]  in_exception,
    input  logic [1:0]  in_excp_flag,
    output logic        space_ok,
    output logic        nearly_full,
    output logic        write_en,
    output logic        pop_en,
    input  logic [1:0]  dec_pop,
    output logic        out_valid0,
    output logic        out_valid1,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic [31:0] out_inst0,
    output logic [31:0] out_inst1,
    output logic [31:0] out_pc_next0,
    output logic [31:0] out_pc_next1,
    output logic [31:0] out_badv0,
    output logic [31:0] out_badv1,
    output logic        out_taken0,
    output logic        out_taken1,
    output logic [6:0]  out_exception0,
    output logic [6:0]  out_exception1,
    output logic [1:0]  out_excp_flag0,
    output logic [1:0]  out_excp_flag1
);

    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free_c, push_n_c, pop_n_c;
    logic          two_c;
    iq_entry_t     wd0_c, wd1_c, rd0_c, rd1_c, o0_c, o1_c;

    // Back-pressure looks only at registered occupancy; same-cycle pops are not credited.
    assign free_c       = CW'(DEPTH) - count_q;
    assign space_ok     = (free_c >= CW'(2));
    assign fifo_allowin = space_ok;
    assign nearly_full  = (free_c < CW'(4));

    // A bundle carries one instruction if it starts at the odd word or carries an exception.
    assign two_c    = !in_pc[2] && (in_excp_flag == 2'b00);
    assign write_en = in_valid && space_ok && !flush && !rst;
    assign push_n_c = write_en ? (two_c ? CW'(2) : CW'(1)) : CW'(0);

    always_comb begin
        pop_n_c = CW'(dec_pop);
        if (pop_n_c > CW'(2))   pop_n_c = CW'(2);
        if (pop_n_c > count_q) pop_n_c = count_q;
    end

    assign pop_en = (pop_n_c != CW'(0)) && !flush && !rst;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_n_c);
            tail_d  = tail_q + PW'(push_n_c);
            count_d = count_q + push_n_c - pop_n_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slot 0 inherits the bundle prediction only when it is the last instruction of the bundle.
    always_comb begin
        wd0_c           = '0;
        wd0_c.pc        = in_pc;
        wd0_c.inst      = in_inst0;
        wd0_c.pc_next   = two_c ? (in_pc + 32'd4) : in_pc_next;
        wd0_c.taken     = two_c ? 1'b0 : in_pc_taken;
        wd0_c.badv      = in_badv;
        wd0_c.exception = in_exception;
        wd0_c.excp_flag = in_excp_flag;

        wd1_c           = '0;
        wd1_c.pc        = in_pc + 32'd4;
        wd1_c.inst      = in_inst1;
        wd1_c.pc_next   = in_pc_next;
        wd1_c.taken     = in_pc_taken;
    end

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ram (
        .clk   (clk),
        .we0_i (write_en),
        .wa0_i (tail_q),
        .wd0_i (wd0_c),
        .we1_i (write_en && two_c),
        .wa1_i (tail_q + PW'(1)),
        .wd1_i (wd1_c),
        .ra0_i (head_q),
        .ra1_i (head_q + PW'(1)),
        .rd0_o (rd0_c),
        .rd1_o (rd1_c)
    );

    assign out_valid0 = (count_q != CW'(0));
    assign out_valid1 = (count_q >= CW'(2));
    assign o0_c       = out_valid0 ? rd0_c : idle_entry();
    assign o1_c       = out_valid1 ? rd1_c : idle_entry();

    assign out_pc0        = o0_c.pc;
    assign out_inst0      = o0_c.inst;
    assign out_pc_next0   = o0_c.pc_next;
    assign out_taken0     = o0_c.taken;
    assign out_badv0      = o0_c.badv;
    assign out_exception0 = o0_c.exception;
    assign out_excp_flag0 = o0_c.excp_flag;

    assign out_pc1        = o1_c.pc;
    assign out_inst1      = o1_c.inst;
    assign out_pc_next1   = o1_c.pc_next;
    assign out_taken1     = o1_c.taken;
    assign out_badv1      = o1_c.badv;
    assign out_exception1 = o1_c.exception;
    assign out_excp_flag1 = o1_c.excp_flag;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed boundary sequence followed by random traffic.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_pc_taken = 1'b0;
    logic [31:0] in_pc = '0, in_pc_next = '0, in_badv = '0, in_inst0 = '0, in_inst1 = '0;
    logic [6:0]  in_exception = '0;
    logic [1:0]  in_excp_flag = '0, dec_pop = '0;
    logic        fifo_allowin, space_ok, nearly_full, write_en, pop_en, out_valid0, out_valid1;
    logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1, out_pc_next0, out_pc_next1;
    logic [31:0] out_badv0, out_badv1;
    logic        out_taken0, out_taken1;
    logic [6:0]  out_exception0, out_exception1;
    logic [1:0]  out_excp_flag0, out_excp_flag1;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .fifo_allowin(fifo_allowin),
        .in_pc(in_pc), .in_pc_next(in_pc_next), .in_badv(in_badv), .in_pc_taken(in_pc_taken),
        .in_inst0(in_inst0), .in_inst1(in_inst1), .in_exception(in_exception),
        .in_excp_flag(in_excp_flag), .space_ok(space_ok), .nearly_full(nearly_full),
        .write_en(write_en), .pop_en(pop_en), .dec_pop(dec_pop),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_pc0(out_pc0), .out_pc1(out_pc1), .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_pc_next0(out_pc_next0), .out_pc_next1(out_pc_next1),
        .out_badv0(out_badv0), .out_badv1(out_badv1),
        .out_taken0(out_taken0), .out_taken1(out_taken1),
        .out_exception0(out_exception0), .out_exception1(out_exception1),
        .out_excp_flag0(out_excp_flag0), .out_excp_flag1(out_excp_flag1)
    );

    always #5 clk = ~clk;

    iq_entry_t exp_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    bit        mon_en   = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chke(input string name, input iq_entry_t act, input iq_entry_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pc=%h inst=%h nxt=%h tk=%b badv=%h exc=%h fl=%b expected pc=%h inst=%h nxt=%h tk=%b badv=%h exc=%h fl=%b at %0t",
                     name, act.pc, act.inst, act.pc_next, act.taken, act.badv, act.exception,
                     act.excp_flag, exp.pc, exp.inst, exp.pc_next, exp.taken, exp.badv,
                     exp.exception, exp.excp_flag, $time);
        end
    endtask

    // Drive one cycle of stimulus and update the reference queue after the clock edge.
    task automatic step(input logic r, input logic fl, input logic v, input logic [31:0] pc,
                        input logic [31:0] pnext, input logic tk, input logic [6:0] exc,
                        input logic [1:0] flag, input logic [1:0] dp);
        iq_entry_t e0, e1;
        bit        fire, two;
        int        cnt;
        @(negedge clk);
        rst = r; flush = fl; in_valid = v; in_pc = pc; in_pc_next = pnext; in_pc_taken = tk;
        in_exception = exc; in_excp_flag = flag; dec_pop = dp;
        in_inst0 = $urandom(); in_inst1 = $urandom(); in_badv = $urandom();
        cnt  = exp_q.size();
        fire = !r && !fl && v && (DEPTH - cnt >= 2);
        two  = (pc[2] == 1'b0) && (flag == 2'b00);
        e0 = '{pc: pc, inst: in_inst0, pc_next: two ? pc + 32'd4 : pnext,
               taken: two ? 1'b0 : tk, badv: in_badv, exception: exc, excp_flag: flag};
        e1 = '{pc: pc + 32'd4, inst: in_inst1, pc_next: pnext, taken: tk,
               badv: 32'd0, exception: 7'd0, excp_flag: 2'd0};
        @(posedge clk);
        #1;
        if (r || fl) exp_q.delete();
        else if (fire) begin
            exp_q.push_back(e0);
            if (two) exp_q.push_back(e1);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] pnext, input logic tk,
                        input logic [1:0] dp);
        step(1'b0, 1'b0, 1'b1, pc, pnext, tk, 7'd0, 2'd0, dp);
    endtask

    task automatic idle(input logic [1:0] dp);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 7'd0, 2'd0, dp);
    endtask

    // Monitor: compares the presented window and handshakes against the reference queue.
    initial begin
        int        cnt, p;
        iq_entry_t a0, a1, e0, e1;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                cnt = exp_q.size();
                chk1("out_valid0", out_valid0, cnt >= 1);
                chk1("out_valid1", out_valid1, cnt >= 2);
                chk1("fifo_allowin", fifo_allowin, DEPTH - cnt >= 2);
                chk1("space_ok", space_ok, DEPTH - cnt >= 2);
                chk1("nearly_full", nearly_full, DEPTH - cnt < 4);
                chk1("write_en", write_en, !rst && !flush && in_valid && (DEPTH - cnt >= 2));
                p = (int'(dec_pop) > cnt) ? cnt : int'(dec_pop);
                chk1("pop_en", pop_en, !rst && !flush && p != 0);
                a0 = '{pc: out_pc0, inst: out_inst0, pc_next: out_pc_next0, taken: out_taken0,
                       badv: out_badv0, exception: out_exception0, excp_flag: out_excp_flag0};
                a1 = '{pc: out_pc1, inst: out_inst1, pc_next: out_pc_next1, taken: out_taken1,
                       badv: out_badv1, exception: out_exception1, excp_flag: out_excp_flag1};
                e0 = (cnt >= 1) ? exp_q[0] : idle_entry();
                e1 = (cnt >= 2) ? exp_q[1] : idle_entry();
                chke("head_entry", a0, e0);
                chke("next_entry", a1, e1);
                if (!rst && !flush) repeat (p) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] pc;
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 7'd0, 2'd0, 2'd0);
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 7'd0, 2'd0, 2'd2);
        mon_en = 1'b1;

        // Two-instruction bundle, then a single odd-word bundle shown alone.
        push(PC_RESET, PC_RESET + 32'h8, 1'b0, 2'd0);
        push(PC_RESET + 32'h14, 32'h1C00_0040, 1'b1, 2'd2);
        idle(2'd0);
        // Exception bundle is a single entry even at an even word.
        step(1'b0, 1'b0, 1'b1, PC_RESET + 32'h20, PC_RESET + 32'h28, 1'b0, 7'h08, 2'b01, 2'd0);
        push(PC_RESET + 32'h40, PC_RESET + 32'h48, 1'b0, 2'd0);
        idle(2'd0);
        // Flush with concurrent push and pop at count 4.
        step(1'b0, 1'b1, 1'b1, PC_RESET + 32'h80, PC_RESET + 32'h88, 1'b0, 7'd0, 2'd0, 2'd2);
        idle(2'd0);

        // Fill to DEPTH-1, try to push while full (with and without a pop).
        pc = PC_RESET + 32'h104;
        push(pc, pc + 32'd4, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            pc = PC_RESET + 32'h200 + 32'(i * 8);
            push(pc, pc + 32'd8, i[0], 2'd0);
        end
        push(PC_RESET + 32'h300, PC_RESET + 32'h308, 1'b0, 2'd2);
        push(PC_RESET + 32'h404, PC_RESET + 32'h408, 1'b1, 2'd0);
        // Steady push(2)+pop(2) at DEPTH-2 across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            pc = PC_RESET + 32'h500 + 32'(i * 8);
            push(pc, pc + 32'd8, 1'b1, 2'd2);
        end
        repeat (4) idle(2'd2);
        // Empty boundary: pop 2 at count 1, then at count 0.
        push(PC_RESET + 32'h604, PC_RESET + 32'h700, 1'b1, 2'd0);
        idle(2'd2);
        idle(2'd2);

        // Random traffic, including rare flushes and resets.
        for (int i = 0; i < 1500; i++) begin
            logic r, fl, v;
            logic [1:0] flag;
            r    = ($urandom_range(199) == 0);
            fl   = ($urandom_range(49) == 0);
            v    = ($urandom_range(9) < 7);
            flag = ($urandom_range(5) == 0) ? 2'($urandom_range(3)) : 2'b00;
            step(r, fl, v, $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC,
                 1'($urandom_range(1)), 7'($urandom()), flag, 2'($urandom_range(2)));
        end
        idle(2'd0);
        @(negedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
